// File: rtl/calc_pkg.sv
// Shared calculator types: the BCD number format and the 7-segment decoder.
package calc_pkg;
    localparam int NumDigits = 8;
    localparam int ShiftW    = $clog2(NumDigits);
    localparam int ExpW      = 4;

    typedef struct packed {
        logic [NumDigits-1:0][3:0] sig;
        logic [ExpW-1:0]           exponent;
    } num_t;

    // Segment bits 0..6 are a..g; bit 7 (decimal point) is left clear.
    function automatic logic [7:0] bcd2segments(input logic [3:0] bcd);
        logic [7:0] seg;
        case (bcd)
            4'd0:    seg = 8'h3F;
            4'd1:    seg = 8'h06;
            4'd2:    seg = 8'h5B;
            4'd3:    seg = 8'h4F;
            4'd4:    seg = 8'h66;
            4'd5:    seg = 8'h6D;
            4'd6:    seg = 8'h7D;
            4'd7:    seg = 8'h07;
            4'd8:    seg = 8'h7F;
            4'd9:    seg = 8'h6F;
            default: seg = 8'h00;
        endcase
        return seg;
    endfunction
endpackage

// File: rtl/display_scanner_pkg.sv
// Types local to the display scanner.
package display_scanner_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ANALYZE = 2'd1,
        ST_BUILD   = 2'd2
    } state_t;
endpackage

// File: rtl/display_scanner_scan_timer.sv
// Free-running digit scan: refresh divider, scan index, frame counter, blink phase.
module scan_timer #(
    parameter int NumDigits  = 8,
    parameter int RefreshDiv = 1024,
    parameter int BlinkDiv   = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    output logic [$clog2(NumDigits)-1:0] scan_idx_o,
    output logic                         blink_on_o
);
    localparam int IdxW = $clog2(NumDigits);
    localparam int RefW = $clog2(RefreshDiv);
    localparam int FrmW = (BlinkDiv > 1) ? $clog2(BlinkDiv) : 1;

    logic [RefW-1:0] ref_cnt_q;
    logic [FrmW-1:0] frame_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ref_cnt_q   <= '0;
            scan_idx_o  <= '0;
            frame_cnt_q <= '0;
            blink_on_o  <= 1'b1;
        end else if (ref_cnt_q == RefW'(RefreshDiv - 1)) begin
            ref_cnt_q <= '0;
            if (scan_idx_o == IdxW'(NumDigits - 1)) begin
                scan_idx_o <= '0;
                if (frame_cnt_q == FrmW'(BlinkDiv - 1)) begin
                    frame_cnt_q <= '0;
                    blink_on_o  <= ~blink_on_o;
                end else begin
                    frame_cnt_q <= frame_cnt_q + FrmW'(1);
                end
            end else begin
                scan_idx_o <= scan_idx_o + IdxW'(1);
            end
        end else begin
            ref_cnt_q <= ref_cnt_q + RefW'(1);
        end
    end
endmodule

// File: rtl/display_scanner.sv
// Accepts a BCD number, builds a segment frame digit by digit into a shadow
// buffer, commits it atomically, and scans the committed frame onto the display.
//
// Handshake: a number is taken on any rising edge where num_valid_i and
// num_ready_o are both high; num_ready_o is registered and never depends on
// num_valid_i, and num_valid_i is ignored while a conversion is in flight.
module display_scanner
    import calc_pkg::*;
    import display_scanner_pkg::*;
#(
    parameter int NumDigits  = calc_pkg::NumDigits,
    parameter int RefreshDiv = 1024,
    parameter int BlinkDiv   = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 num_valid_i,
    output logic                 num_ready_o,
    input  num_t                 num_i,
    input  logic                 override_shift_amount_i,
    input  logic [ShiftW-1:0]    new_shift_amount_i,
    input  logic                 blank_zeros_i,
    input  logic                 blink_i,
    output logic [NumDigits-1:0] digit_sel_o,
    output logic [7:0]           segments_o,
    output state_t               state_o
);
    localparam int IdxW = $clog2(NumDigits);

    state_t                     state_q, state_d;
    logic [IdxW-1:0]            cnt_q;
    logic [NumDigits-1:0][3:0]  sig_q;
    logic [IdxW-1:0]            p_q, dp_q, msd_q, shift_q;
    logic                       ovr_q, blank_q, msd_found_q, dp_none_q;
    logic [ShiftW-1:0]          new_shift_q;
    logic [NumDigits-1:0][7:0]  shadow_q, active_q, shadow_d;
    logic                       accept;
    logic [IdxW-1:0]            p_in, dp_upd, msd_upd, shift_ovr, dp_fin, shift_fin;
    logic                       nz, dp_none_fin;
    logic [IdxW:0]              src;
    logic [7:0]                 seg_w;
    logic [IdxW-1:0]            scan_idx;
    logic                       blink_on;

    assign accept  = num_valid_i && num_ready_o;
    assign state_o = state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = ST_ANALYZE;
            ST_ANALYZE: if (cnt_q == '0) state_d = ST_BUILD;
            ST_BUILD:   if (cnt_q == IdxW'(NumDigits - 1)) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // ANALYZE walks i downward, so the last qualifying digit below P is the lowest one.
    always_comb begin
        p_in = (int'(num_i.exponent) > NumDigits - 1) ? '0
             : IdxW'(NumDigits - 1 - int'(num_i.exponent));
        nz          = (sig_q[cnt_q] != 4'd0);
        dp_upd      = (nz && cnt_q < p_q) ? p_q - cnt_q : dp_q;
        msd_upd     = (nz && !msd_found_q) ? cnt_q : msd_q;
        shift_ovr   = (int'(new_shift_q) > NumDigits - 1) ? IdxW'(NumDigits - 1)
                    : IdxW'(new_shift_q);
        dp_none_fin = ovr_q && (shift_ovr > p_q);
        dp_fin      = ovr_q ? p_q - shift_ovr : dp_upd;
        shift_fin   = ovr_q ? shift_ovr : p_q - dp_upd;

        src   = {1'b0, cnt_q} + {1'b0, shift_q};
        seg_w = 8'h00;
        if (int'(src) <= NumDigits - 1) seg_w = bcd2segments(sig_q[src[IdxW-1:0]]);
        if (blank_q && src > {1'b0, msd_q} && (dp_none_q || cnt_q > dp_q)) seg_w = 8'h00;
        if (!dp_none_q && cnt_q == dp_q) seg_w[7] = 1'b1;

        shadow_d        = shadow_q;
        shadow_d[cnt_q] = seg_w;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            sig_q       <= '0;
            p_q         <= '0;
            dp_q        <= '0;
            msd_q       <= '0;
            shift_q     <= '0;
            ovr_q       <= 1'b0;
            blank_q     <= 1'b0;
            msd_found_q <= 1'b0;
            dp_none_q   <= 1'b0;
            new_shift_q <= '0;
            shadow_q    <= '0;
            active_q    <= '0;
            num_ready_o <= 1'b0;
        end else begin
            num_ready_o <= (state_d == ST_IDLE);
            case (state_q)
                ST_IDLE: if (accept) begin
                    sig_q       <= num_i.sig;
                    p_q         <= p_in;
                    ovr_q       <= override_shift_amount_i;
                    new_shift_q <= new_shift_amount_i;
                    blank_q     <= blank_zeros_i;
                    cnt_q       <= IdxW'(NumDigits - 1);
                    dp_q        <= '0;
                    msd_q       <= '0;
                    msd_found_q <= 1'b0;
                    dp_none_q   <= 1'b0;
                end
                ST_ANALYZE: begin
                    dp_q        <= dp_upd;
                    msd_q       <= msd_upd;
                    msd_found_q <= msd_found_q | nz;
                    if (cnt_q == '0) begin
                        shift_q   <= shift_fin;
                        dp_q      <= dp_fin;
                        dp_none_q <= dp_none_fin;
                    end else begin
                        cnt_q <= cnt_q - IdxW'(1);
                    end
                end
                ST_BUILD: begin
                    shadow_q <= shadow_d;
                    if (cnt_q == IdxW'(NumDigits - 1)) begin
                        active_q <= shadow_d;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + IdxW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    scan_timer #(
        .NumDigits (NumDigits),
        .RefreshDiv(RefreshDiv),
        .BlinkDiv  (BlinkDiv)
    ) u_scan_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .scan_idx_o(scan_idx),
        .blink_on_o(blink_on)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digit_sel_o <= NumDigits'(1);
            segments_o  <= 8'h00;
        end else begin
            digit_sel_o <= NumDigits'(1) << scan_idx;
            segments_o  <= (blink_i && !blink_on) ? 8'h00 : active_q[scan_idx];
        end
    end
endmodule
